peripheral_arbiter_ahb4: RTL

PERIPHERAL_ARBITER_AHB4 -- requirements
Module: peripheral_arbiter_ahb4

---
 rtl/peripheral_arbiter_ahb4.sv | 135 +++++++++++++
 1 files changed

// File: rtl/peripheral_arbiter_ahb4.sv
// Two-master round-robin arbiter onto a single slave port; owner keeps the bus while its cyc is high.
// Optional stall watchdog compiled in with PERIPHERAL_ARBITER_AHB4_TIMEOUT_EN.
module peripheral_arbiter_ahb4 #(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            ahb4_clk_i,
  input  logic            ahb4_rst_i,
  input  logic [2*AW-1:0] ahb4_m_adr_i,
  input  logic [2*DW-1:0] ahb4_m_dat_i,
  input  logic [7:0]      ahb4_m_sel_i,
  input  logic [1:0]      ahb4_m_we_i,
  input  logic [5:0]      ahb4_m_cti_i,
  input  logic [3:0]      ahb4_m_bte_i,
  input  logic [1:0]      ahb4_m_cyc_i,
  input  logic [1:0]      ahb4_m_stb_i,
  output logic [1:0]      ahb4_m_ack_o,
  output logic [1:0]      ahb4_m_err_o,
  output logic [DW-1:0]   ahb4_m_dat_o,
  output logic [AW-1:0]   ahb4_s_adr_o,
  output logic [DW-1:0]   ahb4_s_dat_o,
  output logic [3:0]      ahb4_s_sel_o,
  output logic            ahb4_s_we_o,
  output logic [2:0]      ahb4_s_cti_o,
  output logic [1:0]      ahb4_s_bte_o,
  output logic            ahb4_s_cyc_o,
  output logic            ahb4_s_stb_o,
  input  logic            ahb4_s_ack_i,
  input  logic            ahb4_s_err_i,
  input  logic [DW-1:0]   ahb4_s_dat_i,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   win;
  logic   owned, own_idx;
  logic   stb_raw;
  logic   fire;

  always_ff @(posedge ahb4_clk_i) begin
    if (ahb4_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    win       = 1'b0;
    case (state)
      IDLE: begin
        if (ahb4_m_cyc_i != 2'b00) begin
          // On a tie the master not granted last wins
          win       = (&ahb4_m_cyc_i) ? ~last : ahb4_m_cyc_i[1];
          state_nxt = win ? OWN1 : OWN0;
          last_nxt  = win;
        end
      end
      OWN0: begin
        if (!ahb4_m_cyc_i[0]) begin
          state_nxt = ahb4_m_cyc_i[1] ? OWN1 : IDLE;
          last_nxt  = ahb4_m_cyc_i[1] ? 1'b1 : last;
        end
      end
      OWN1: begin
        if (!ahb4_m_cyc_i[1]) begin
          state_nxt = ahb4_m_cyc_i[0] ? OWN0 : IDLE;
          last_nxt  = ahb4_m_cyc_i[0] ? 1'b0 : last;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign owned   = (state == OWN0) || (state == OWN1);
  assign own_idx = (state == OWN1);
  assign grant_o = {state == OWN1, state == OWN0};
  assign ahb4_m_dat_o = ahb4_s_dat_i;

  always_comb begin
    ahb4_s_adr_o = '0;
    ahb4_s_dat_o = '0;
    ahb4_s_sel_o = '0;
    ahb4_s_we_o  = 1'b0;
    ahb4_s_cti_o = '0;
    ahb4_s_bte_o = '0;
    ahb4_s_cyc_o = 1'b0;
    stb_raw      = 1'b0;
    ahb4_m_ack_o = '0;
    ahb4_m_err_o = '0;
    if (owned) begin
      ahb4_s_adr_o = own_idx ? ahb4_m_adr_i[2*AW-1:AW] : ahb4_m_adr_i[AW-1:0];
      ahb4_s_dat_o = own_idx ? ahb4_m_dat_i[2*DW-1:DW] : ahb4_m_dat_i[DW-1:0];
      ahb4_s_sel_o = own_idx ? ahb4_m_sel_i[7:4] : ahb4_m_sel_i[3:0];
      ahb4_s_we_o  = ahb4_m_we_i[own_idx];
      ahb4_s_cti_o = own_idx ? ahb4_m_cti_i[5:3] : ahb4_m_cti_i[2:0];
      ahb4_s_bte_o = own_idx ? ahb4_m_bte_i[3:2] : ahb4_m_bte_i[1:0];
      ahb4_s_cyc_o = ahb4_m_cyc_i[own_idx];
      stb_raw      = ahb4_m_stb_i[own_idx];
      ahb4_m_ack_o[own_idx] = ahb4_s_ack_i;
      ahb4_m_err_o[own_idx] = ahb4_s_err_i | fire;
    end
  end

  assign ahb4_s_stb_o = stb_raw & ~fire;

`ifdef PERIPHERAL_ARBITER_AHB4_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] stall_cnt;

  assign fire = owned && (stall_cnt == CW'(TIMEOUT));

  always_ff @(posedge ahb4_clk_i) begin
    if (ahb4_rst_i || fire || ahb4_s_ack_i || ahb4_s_err_i || (state_nxt != state)) begin
      stall_cnt <= '0;
    end else if (stb_raw) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign fire = 1'b0;
`endif

endmodule
